// File: rtl/instr_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch buffer and its FIFO.
package instr_prefetch_pkg;

  localparam int INSTR_WIDTH  = 32;
  localparam int FETCH_STRIDE = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] rdata;
    logic [INSTR_WIDTH-1:0] addr;
  } fifo_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// In-order instruction FIFO; head is registered (no fall-through), flush clears all entries.
module instr_fetch_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  fifo_entry_t                  i_entry,
  output fifo_entry_t                  o_entry,
  output logic                         o_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fifo_entry_t      r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0) && !i_flush;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_push = i_push && !i_flush && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_valid = (r_count != '0);
  assign o_entry = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: one request in flight, results buffered in a FIFO, branch redirect.
module instr_prefetch_buffer
  import instr_prefetch_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_enable_i,
  input  logic                   branch_i,
  input  logic [INSTR_WIDTH-1:0] branch_addr_i,
  output logic                   valid_o,
  output logic [INSTR_WIDTH-1:0] rdata_o,
  output logic [INSTR_WIDTH-1:0] addr_o,
  input  logic                   ready_i,
  output logic                   req_o,
  output logic [INSTR_WIDTH-1:0] fetch_addr_o,
  input  logic                   ack_i,
  input  logic [INSTR_WIDTH-1:0] rdata_i,
  output logic                   stall_if_o,
  output logic                   drop_request_o
);

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_e           r_state;
  fetch_state_e           w_state_nxt;
  logic [INSTR_WIDTH-1:0] r_next_addr;
  logic [INSTR_WIDTH-1:0] r_pend_addr;
  logic [CW-1:0]          w_count;
  logic [CW:0]            w_occ;
  logic                   w_fifo_valid;
  logic                   w_resp_acc;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_req;
  logic                   w_stall;
  logic                   w_unused_addr_lsbs;
  fifo_entry_t            w_push_entry;
  fifo_entry_t            w_head;

  assign w_unused_addr_lsbs = ^branch_addr_i[1:0];

  assign w_stall    = (w_count == CW'(DEPTH)) && (r_state == BUSY);
  assign w_resp_acc = ack_i && !w_stall;
  assign w_pop      = w_fifo_valid && ready_i && !branch_i;
  // Occupancy after this cycle, counting the in-flight word as already buffered.
  assign w_occ      = {1'b0, w_count}
                    + {{CW{1'b0}}, (r_state != IDLE)}
                    - {{CW{1'b0}}, w_pop};

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_push      = 1'b0;
    // rst_n in the term keeps req_o low for the whole reset window.
    if (rst_n && fetch_enable_i && !branch_i && (w_occ < (CW+1)'(DEPTH))
        && ((r_state == IDLE) || ((r_state == BUSY) && w_resp_acc)))
      w_req = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_req) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (branch_i) begin
          w_state_nxt = w_resp_acc ? IDLE : DISCARD;
        end else if (w_resp_acc) begin
          w_push      = 1'b1;
          w_state_nxt = w_req ? BUSY : IDLE;
        end
      end
      DISCARD: begin
        if (w_resp_acc) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_next_addr <= RESET_ADDR;
      r_pend_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (branch_i) begin
        r_next_addr <= {branch_addr_i[INSTR_WIDTH-1:2], 2'b00};
      end else if (w_req) begin
        r_pend_addr <= r_next_addr;
        r_next_addr <= r_next_addr + INSTR_WIDTH'(FETCH_STRIDE);
      end
    end
  end

  assign w_push_entry = '{rdata: rdata_i, addr: r_pend_addr};

  instr_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (branch_i),
    .i_entry (w_push_entry),
    .o_entry (w_head),
    .o_valid (w_fifo_valid),
    .o_count (w_count)
  );

  assign valid_o        = w_fifo_valid && !branch_i;
  assign rdata_o        = w_head.rdata;
  assign addr_o         = w_head.addr;
  assign req_o          = w_req;
  assign fetch_addr_o   = r_next_addr;
  assign stall_if_o     = w_stall;
  assign drop_request_o = branch_i;

  a_no_stall: assert property (@(posedge clk) disable iff (!rst_n) !w_stall);

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Scoreboard bench for instr_prefetch_buffer with a latency-programmable core-interface responder.
module tb_instr_prefetch_buffer;

  localparam int          DEPTH      = 4;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_enable_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        ready_i;
  logic        req_o;
  logic [31:0] fetch_addr_o;
  logic        ack_i;
  logic [31:0] rdata_i;
  logic        stall_if_o;
  logic        drop_request_o;

  always #5 clk = ~clk;

  instr_prefetch_buffer #(
    .DEPTH      (DEPTH),
    .RESET_ADDR (RESET_ADDR)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_enable_i (fetch_enable_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .valid_o        (valid_o),
    .rdata_o        (rdata_o),
    .addr_o         (addr_o),
    .ready_i        (ready_i),
    .req_o          (req_o),
    .fetch_addr_o   (fetch_addr_o),
    .ack_i          (ack_i),
    .rdata_i        (rdata_i),
    .stall_if_o     (stall_if_o),
    .drop_request_o (drop_request_o)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pop    = 0;
  int          lat      = 2;
  int          rsp_cnt  = 0;
  logic        rsp_pend = 1'b0;
  logic [31:0] rsp_addr = '0;
  logic [31:0] model_addr = RESET_ADDR;
  logic        req_this = 1'b0;
  logic [31:0] req_addr_this = '0;
  logic [63:0] exp_q [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_5A3C;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Observe one cycle at the falling edge: scoreboard, reference address model, responder bookkeeping.
  task automatic sample();
    logic [63:0] e;
    req_this = 1'b0;
    if (!rst_n) begin
      rsp_pend   = 1'b0;
      exp_q.delete();
      model_addr = RESET_ADDR;
      return;
    end
    check_eq("stall_never", 32'(stall_if_o), 0);
    check_eq("drop_pulse", 32'(drop_request_o), 32'(branch_i));
    if (branch_i) check_eq("branch_valid_low", 32'(valid_o), 0);
    if (valid_o && ready_i && !branch_i) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_output", 32'(valid_o), 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_addr", addr_o, e[63:32]);
        check_eq("out_data", rdata_o, e[31:0]);
      end
    end
    if (ack_i && !stall_if_o) rsp_pend = 1'b0;
    if (branch_i) begin
      exp_q.delete();
      model_addr = {branch_addr_i[31:2], 2'b00};
      check_eq("branch_no_req", 32'(req_o), 0);
    end
    if (!fetch_enable_i) check_eq("disabled_no_req", 32'(req_o), 0);
    if (req_o) begin
      req_this      = 1'b1;
      req_addr_this = fetch_addr_o;
      check_eq("one_outstanding", 32'(rsp_pend), 0);
      check_eq("req_addr", fetch_addr_o, model_addr);
      rsp_pend = 1'b1;
      rsp_cnt  = lat;
      rsp_addr = fetch_addr_o;
      exp_q.push_back({model_addr, mem_word(model_addr)});
      model_addr = model_addr + 32'd4;
    end
  endtask

  task automatic drive_resp();
    if (rst_n && rsp_pend) begin
      if (rsp_cnt > 0) rsp_cnt--;
      if (rsp_cnt == 0) begin
        ack_i   = 1'b1;
        rdata_i = mem_word(rsp_addr);
      end else begin
        ack_i   = 1'b0;
        rdata_i = 32'hDEAD_BEEF;
      end
    end else begin
      ack_i   = 1'b0;
      rdata_i = 32'hDEAD_BEEF;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive_resp();
  endtask

  task automatic wait_req(input logic [31:0] a, input int budget, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (req_this && req_addr_this == a) found = 1'b1;
    end
    check_eq(tag, 32'(found), 1);
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    fetch_enable_i = 1'b0;
    ready_i        = 1'b0;
    branch_i       = 1'b0;
    branch_addr_i  = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int pops0;
    rst_n          = 1'b0;
    fetch_enable_i = 1'b0;
    branch_i       = 1'b0;
    branch_addr_i  = '0;
    ready_i        = 1'b0;
    ack_i          = 1'b0;
    rdata_i        = '0;
    tick();
    tick();
    check_eq("rst_valid", 32'(valid_o), 0);
    check_eq("rst_req", 32'(req_o), 0);
    check_eq("rst_stall", 32'(stall_if_o), 0);
    check_eq("rst_drop", 32'(drop_request_o), 0);
    check_eq("rst_rdata", rdata_o, 0);
    check_eq("rst_addr", addr_o, 0);
    rst_n = 1'b1;

    // Streaming: ack two cycles after each request, IF always ready.
    lat = 2;
    fetch_enable_i = 1'b1;
    ready_i = 1'b1;
    pops0 = n_pop;
    wait_req(32'h0, 4, "s1_first_req");
    wait_req(32'h4, 6, "s1_second_req");
    repeat (20) tick();
    check_eq("s1_stream_pops", 32'((n_pop - pops0) >= 8), 1);

    // Back-pressure fills the FIFO, then resume.
    apply_reset();
    lat = 2;
    fetch_enable_i = 1'b1;
    repeat (30) tick();
    check_eq("s2_buffered", exp_q.size(), DEPTH);
    check_eq("s2_no_inflight", 32'(rsp_pend), 0);
    check_eq("s2_req_held", 32'(req_o), 0);
    check_eq("s2_head_valid", 32'(valid_o), 1);
    ready_i = 1'b1;
    wait_req(32'h10, 10, "s2_resume_0x10");
    repeat (10) tick();

    // Branch while the 0x8 fetch is still in flight.
    apply_reset();
    lat = 3;
    fetch_enable_i = 1'b1;
    ready_i = 1'b1;
    wait_req(32'h8, 20, "s3_req_0x8");
    branch_i = 1'b1;
    branch_addr_i = 32'h0000_1002;
    tick();
    branch_i = 1'b0;
    check_eq("s3_flushed", 32'(valid_o), 0);
    wait_req(32'h1000, 10, "s3_req_0x1000");
    wait_req(32'h1004, 10, "s3_req_0x1004");
    repeat (8) tick();

    // Branch coinciding with the response for 0x4.
    apply_reset();
    lat = 2;
    fetch_enable_i = 1'b1;
    ready_i = 1'b1;
    wait_req(32'h4, 10, "s4_req_0x4");
    for (int i = 0; i < 5 && !ack_i; i++) tick();
    check_eq("s4_ack_present", 32'(ack_i), 1);
    branch_i = 1'b1;
    branch_addr_i = 32'h0000_2000;
    tick();
    branch_i = 1'b0;
    tick();
    check_eq("s4_req_next_cycle", 32'(req_this), 1);
    check_eq("s4_req_addr", req_addr_this, 32'h0000_2000);
    repeat (8) tick();

    // Address wrap at the top of the address space.
    apply_reset();
    lat = 1;
    fetch_enable_i = 1'b1;
    ready_i = 1'b1;
    branch_i = 1'b1;
    branch_addr_i = 32'hFFFF_FFFC;
    tick();
    branch_i = 1'b0;
    wait_req(32'hFFFF_FFFC, 4, "s5_req_top");
    wait_req(32'h0000_0000, 4, "s5_req_wrap");
    repeat (6) tick();

    // Asynchronous reset while busy with three buffered entries.
    apply_reset();
    lat = 1;
    fetch_enable_i = 1'b1;
    for (int i = 0; i < 20 && !(exp_q.size() == 4 && rsp_pend); i++) tick();
    check_eq("s6_pre_valid", 32'(valid_o), 1);
    check_eq("s6_pre_busy", 32'(rsp_pend), 1);
    rst_n = 1'b0;
    #1;
    check_eq("s6_rst_valid", 32'(valid_o), 0);
    check_eq("s6_rst_req", 32'(req_o), 0);
    check_eq("s6_rst_stall", 32'(stall_if_o), 0);
    tick();
    tick();
    rst_n = 1'b1;
    wait_req(RESET_ADDR, 4, "s6_restart_addr");
    ready_i = 1'b1;
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_buffer.md
Name: instr_prefetch_buffer

Overview:
- Sits between the IF stage and instr_core_interface.
- Issues sequential word fetches into instr_core_interface and buffers the returned instructions, with their addresses, in a small FIFO.
- Hands instructions to the IF stage with a valid/ready handshake.
- On a branch it flushes the buffer, discards any fetch still in flight, and restarts fetching at the target.

Parameters:
DEPTH, 4, FIFO entries (power of 2, ≥2)
RESET_ADDR, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
fetch_enable_i  in  1  allow new fetch requests
branch_i  in  1  one-cycle pulse: redirect fetch
branch_addr_i  in  32  redirect target (bits[1:0] ignored)
valid_o  out  1  head entry valid
rdata_o  out  32  head instruction
addr_o  out  32  head instruction address
ready_i  in  1  IF stage consumes head
req_o  out  1  fetch request to core interface
fetch_addr_o  out  32  request address
ack_i  in  1  response data present
rdata_i  in  32  response data
stall_if_o  out  1  response cannot be accepted (hold)
drop_request_o  out  1  branch notification to core interface

Behaviour:
- Reset values:
  - Outputs: valid_o=0, req_o=0, stall_if_o=0, drop_request_o=0; rdata_o/addr_o = 0.
  - Internal: FIFO empty, FSM IDLE, next-fetch address = RESET_ADDR.
- Core interface contract:
  - A request is committed in any cycle with req_o=1 while FSM is IDLE, or in the cycle a response is accepted.
  - fetch_addr_o must be valid in that cycle.
  - ack_i may stay high for several cycles while stall_if_o=1. A response is accepted only when ack_i && !stall_if_o.
- Definitions:
  - resp_acc = ack_i && !stall_if_o
  - pop = valid_o && ready_i && !branch_i
  - out = 1 if FSM ≠ IDLE
- Issue rule: req_o = fetch_enable_i && !branch_i && (count + out − pop < DEPTH) && (FSM==IDLE || resp_acc).
  - The rule guarantees the FIFO never overflows.
  - req_o is combinational from ack_i. There is no loop, because ack_i does not depend on req_o.
- Request bookkeeping: on issue, the current fetch address is recorded as pending, and the next-fetch address becomes +4 (wraps modulo 2^32).
- FSM states:
  - IDLE: no request in flight.
    - req_o → BUSY.
  - BUSY: one request in flight.
    - resp_acc: push {rdata_i, pending addr} into FIFO; next state is BUSY if req_o, else IDLE.
    - branch_i without resp_acc → DISCARD.
    - branch_i together with resp_acc: the response is dropped (not pushed) → IDLE.
  - DISCARD: in-flight response belongs to the old stream.
    - resp_acc: drop the response → IDLE. No request is issued that cycle.
    - A further branch_i in DISCARD stays in DISCARD and updates the target.
- stall_if_o = (count==DEPTH) && FSM==BUSY. It never asserts in DISCARD. Under the issue rule it remains 0; it is a safety net that verification asserts never fires.
- Branch cycle:
  - FIFO flushed, valid_o forced 0, no pop.
  - drop_request_o=1 for that cycle.
  - Next-fetch address := {branch_addr_i[31:2],2'b00}.
  - The first request to the target is issued no earlier than the following cycle (from IDLE).
- FIFO ordering and occupancy:
  - Output is in order.
  - Push and pop in the same cycle are allowed when full or empty. Push while empty gives valid_o the next cycle; there is no fall-through.
  - Pointers wrap modulo DEPTH; count is 0..DEPTH.
- fetch_enable_i low: no new requests. In-flight responses are still accepted and the FIFO still drains.
- Reset mid-operation: all state clears immediately and asynchronously. The core interface is reset by the same rst_n.

Decomposition:
- Package instr_prefetch_pkg holds:
  - FSM enum {IDLE, BUSY, DISCARD}
  - INSTR_WIDTH=32
  - FETCH_STRIDE=4
  - FIFO entry struct {rdata, addr}
- Sub-module instr_fetch_fifo (parameter DEPTH):
  - Ports: push, pop, flush, entry in/out, valid, count.
- The top module contains the FSM, address counter, and issue logic.

Test Plan:
- Reset, fetch_enable=1, ack 2 cycles after each request, ready_i=1 → requests to 0x0, 0x4, 0x8…; addr_o/rdata_o emerge in order with one request outstanding at a time.
- ready_i=0, DEPTH=4 → exactly 4 words buffered, req_o stays 0 afterwards, stall_if_o never 1; set ready_i=1 → fetching resumes at 0x10.
- Branch to 0x1002 while a request to 0x8 is in flight (ack 3 cycles later) → FIFO empty, drop_request_o pulses, the 0x8 data is never output, next request 0x1000, then 0x1004.
- Branch in the same cycle as ack_i for 0x4 → 0x4 dropped, FSM IDLE, request 0x2000 issued the next cycle.
- Next-fetch address 0xFFFF_FFFC, no stall → next request addresses 0xFFFF_FFFC then 0x0000_0000 (wrap).
- Assert rst_n low while in BUSY with FIFO holding 3 entries → valid_o=0, req_o=0 at once; after release, fetch restarts at RESET_ADDR.
